// File: rtl/rsa_exp_arbiter.sv
// rsa_exp_arbiter: two requesters share one Montgomery exponentiation engine.
// Each accepted job moves through five steps:
//   1. Convert the message into the Montgomery domain.
//   2. Start the engine.
//   3. Wait for the engine to finish, with a watchdog running.
//   4. Convert the engine result back to the normal domain.
//   5. Strobe done (or err on a watchdog timeout) to the port that owns the job.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/ready          job handshake per port (ready only in IDLE)
//   reqN_msg/exp/N/N_prime/r2/one   job operands per port
//   reqN_done / reqN_err      one-cycle completion / timeout strobes
//   result                    normal-domain result of the last completed job
//   eng_start, eng_*          engine start pulse and operands (held from START to end of WAIT)
//   eng_finish, eng_result    engine completion pulse and Montgomery-domain result

`ifndef BITS
`define BITS 16
`endif

// montgomery_mult: combinational REDC, o_p = i_a * i_b * R^-1 mod i_n, R = 2^BITS.
// Operands must be < i_n; i_n must be odd; i_n_prime = -i_n^-1 mod R.
module montgomery_mult (
  input  logic [`BITS-1:0] i_a,
  input  logic [`BITS-1:0] i_b,
  input  logic [`BITS-1:0] i_n,
  input  logic [`BITS-1:0] i_n_prime,
  output logic [`BITS-1:0] o_p
);
  localparam int unsigned B = `BITS;

  logic [2*B-1:0] w_t;
  logic [B-1:0]   w_m;
  logic [2*B-1:0] w_mn;
  logic [B:0]     w_u;
  logic [B-1:0]   w_unused_lo;

  always_comb begin
    w_t  = {{B{1'b0}}, i_a} * {{B{1'b0}}, i_b};
    w_m  = w_t[B-1:0] * i_n_prime;
    w_mn = {{B{1'b0}}, w_m} * {{B{1'b0}}, i_n};
    // Low half of the sum is zero by construction; only the upper part is kept.
    {w_u, w_unused_lo} = {1'b0, w_t} + {1'b0, w_mn};
    o_p = (w_u >= {1'b0, i_n}) ? (w_u[B-1:0] - i_n) : w_u[B-1:0];
  end
endmodule

module rsa_exp_arbiter #(
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [`BITS-1:0] req0_msg,
  input  logic [`BITS-1:0] req0_exp,
  input  logic [`BITS-1:0] req0_N,
  input  logic [`BITS-1:0] req0_N_prime,
  input  logic [`BITS-1:0] req0_r2,
  input  logic [`BITS-1:0] req0_one,
  output logic             req0_done,
  output logic             req0_err,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [`BITS-1:0] req1_msg,
  input  logic [`BITS-1:0] req1_exp,
  input  logic [`BITS-1:0] req1_N,
  input  logic [`BITS-1:0] req1_N_prime,
  input  logic [`BITS-1:0] req1_r2,
  input  logic [`BITS-1:0] req1_one,
  output logic             req1_done,
  output logic             req1_err,
  output logic [`BITS-1:0] result,
  output logic             eng_start,
  output logic [`BITS-1:0] eng_base_mont,
  output logic [`BITS-1:0] eng_exponent,
  output logic [`BITS-1:0] eng_N,
  output logic [`BITS-1:0] eng_N_prime,
  output logic [`BITS-1:0] eng_one_mont,
  input  logic             eng_finish,
  input  logic [`BITS-1:0] eng_result
);
  localparam int unsigned B = `BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_TO_MONT, S_START, S_WAIT, S_FROM_MONT, S_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic                 r_last_grant;
  logic                 r_owner;
  logic [B-1:0]         r_msg, r_exp, r_N, r_N_prime, r_r2, r_one;
  logic [B-1:0]         r_base, r_temp, r_result;
  logic [TIMEOUT_W-1:0] r_wd;

  logic         w_gnt0, w_gnt1, w_accept, w_wd_max;
  logic [B-1:0] w_mul_a, w_mul_b, w_mul_p;

  // Round-robin: on a tie the port that did not win last time is granted.
  always_comb begin
    w_gnt0   = (r_state == S_IDLE) && !rst && req0_valid && (!req1_valid || r_last_grant);
    w_gnt1   = (r_state == S_IDLE) && !rst && req1_valid && (!req0_valid || !r_last_grant);
    w_accept = w_gnt0 || w_gnt1;
    w_wd_max = (r_wd == '1);
  end

  always_comb begin
    w_mul_a = r_msg;
    w_mul_b = r_r2;
    if (r_state == S_FROM_MONT) begin
      w_mul_a = r_temp;
      w_mul_b = B'(1);
    end
  end

  montgomery_mult u_mult (
    .i_a       (w_mul_a),
    .i_b       (w_mul_b),
    .i_n       (r_N),
    .i_n_prime (r_N_prime),
    .o_p       (w_mul_p)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_accept) w_state_nxt = S_TO_MONT;
      S_TO_MONT:   w_state_nxt = S_START;
      S_START:     w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (eng_finish)    w_state_nxt = S_FROM_MONT;
        else if (w_wd_max) w_state_nxt = S_IDLE;
      end
      S_FROM_MONT: w_state_nxt = S_DONE;
      S_DONE:      w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = w_gnt0;
    req1_ready = w_gnt1;
    eng_start  = !rst && (r_state == S_START);
    req0_done  = !rst && (r_state == S_DONE) && !r_owner;
    req1_done  = !rst && (r_state == S_DONE) &&  r_owner;
    // Finish in the saturation cycle takes priority over the timeout.
    req0_err   = !rst && (r_state == S_WAIT) && w_wd_max && !eng_finish && !r_owner;
    req1_err   = !rst && (r_state == S_WAIT) && w_wd_max && !eng_finish &&  r_owner;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_msg        <= '0;
      r_exp        <= '0;
      r_N          <= '0;
      r_N_prime    <= '0;
      r_r2         <= '0;
      r_one        <= '0;
      r_base       <= '0;
      r_temp       <= '0;
      r_result     <= '0;
      r_wd         <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_owner      <= w_gnt1;
          r_last_grant <= w_gnt1;
          r_msg        <= w_gnt1 ? req1_msg     : req0_msg;
          r_exp        <= w_gnt1 ? req1_exp     : req0_exp;
          r_N          <= w_gnt1 ? req1_N       : req0_N;
          r_N_prime    <= w_gnt1 ? req1_N_prime : req0_N_prime;
          r_r2         <= w_gnt1 ? req1_r2      : req0_r2;
          r_one        <= w_gnt1 ? req1_one     : req0_one;
        end
        S_TO_MONT:   r_base <= w_mul_p;
        S_START:     r_wd   <= '0;
        S_WAIT: begin
          r_wd <= r_wd + 1'b1;
          if (eng_finish) r_temp <= eng_result;
        end
        S_FROM_MONT: r_result <= w_mul_p;
        default: ;
      endcase
    end
  end

  assign result        = r_result;
  assign eng_base_mont = r_base;
  assign eng_exponent  = r_exp;
  assign eng_N         = r_N;
  assign eng_N_prime   = r_N_prime;
  assign eng_one_mont  = r_one;
endmodule

// File: tb/tb_rsa_exp_arbiter.sv
// Bench for rsa_exp_arbiter. A behavioural ladder engine sits on the eng_* port,
// with configurable latency and a mode in which it never finishes. Expected
// results come from a plain square-and-multiply model.
module tb_rsa_exp_arbiter;
  localparam int B = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_done, req0_err;
  logic [B-1:0] req0_msg, req0_exp, req0_N, req0_N_prime, req0_r2, req0_one;
  logic         req1_valid, req1_ready, req1_done, req1_err;
  logic [B-1:0] req1_msg, req1_exp, req1_N, req1_N_prime, req1_r2, req1_one;
  logic [B-1:0] result;
  logic         eng_start, eng_finish;
  logic [B-1:0] eng_base_mont, eng_exponent, eng_N, eng_N_prime, eng_one_mont, eng_result;

  always #5 clk = ~clk;

  rsa_exp_arbiter #(.TIMEOUT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_msg(req0_msg),
    .req0_exp(req0_exp), .req0_N(req0_N), .req0_N_prime(req0_N_prime),
    .req0_r2(req0_r2), .req0_one(req0_one), .req0_done(req0_done), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_msg(req1_msg),
    .req1_exp(req1_exp), .req1_N(req1_N), .req1_N_prime(req1_N_prime),
    .req1_r2(req1_r2), .req1_one(req1_one), .req1_done(req1_done), .req1_err(req1_err),
    .result(result), .eng_start(eng_start), .eng_base_mont(eng_base_mont),
    .eng_exponent(eng_exponent), .eng_N(eng_N), .eng_N_prime(eng_N_prime),
    .eng_one_mont(eng_one_mont), .eng_finish(eng_finish), .eng_result(eng_result)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // ---------------- reference math ----------------
  function automatic longint modexp(input longint m, input longint e, input longint n);
    longint r = 1 % n;
    longint b = m % n;
    for (int i = 0; i < B; i++) begin
      if (e[i]) r = (r * b) % n;
      b = (b * b) % n;
    end
    return r;
  endfunction

  // Bit-serial Montgomery product, used only by the engine stand-in.
  function automatic longint mont_ref(input longint a, input longint b, input longint n);
    longint x = a * b;
    for (int i = 0; i < B; i++) begin
      if (x[0]) x = x + n;
      x = x >> 1;
    end
    if (x >= n) x = x - n;
    return x;
  endfunction

  function automatic longint calc_np(input longint n);
    longint x = n;
    for (int i = 0; i < 5; i++) x = (x * (2 - n * x)) & 64'hFFFF;
    return (65536 - x) & 64'hFFFF;
  endfunction

  // ---------------- engine stand-in ----------------
  int eng_lat  = 4;
  bit eng_hang = 1'b0;

  initial begin
    longint acc, base, n;
    eng_finish = 1'b0;
    eng_result = '0;
    forever begin
      @(negedge clk);
      if (eng_start && !rst && !eng_hang) begin
        n    = eng_N;
        base = eng_base_mont;
        acc  = eng_one_mont;
        for (int i = B - 1; i >= 0; i--) begin
          acc = mont_ref(acc, acc, n);
          if (eng_exponent[i]) acc = mont_ref(acc, base, n);
        end
        repeat (eng_lat) @(posedge clk);
        #1 eng_result = B'(acc);
        eng_finish = 1'b1;
        @(posedge clk);
        #1 eng_finish = 1'b0;
      end
    end
  end

  // ---------------- scoreboard and monitor ----------------
  typedef struct {
    int     port;
    bit     is_err;
    longint val;
    string  tag;
  } exp_t;
  exp_t   sb[$];
  longint last_res = 0;

  int cyc = 0;
  int acc_cyc, start_cyc, fin_cyc, evt_cyc;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acc_cyc = cyc;
      if (eng_start)  start_cyc = cyc;
      if (eng_finish) fin_cyc   = cyc;
      if (req0_done || req1_done || req0_err || req1_err) begin
        evt_cyc = cyc;
        if (sb.size() == 0) check("unexpected_strobe", 1, 0);
        else begin
          e = sb.pop_front();
          check({e.tag, "_strobes"}, int'(req0_done) + int'(req1_done) + int'(req0_err) + int'(req1_err), 1);
          check({e.tag, "_port"}, (req1_done || req1_err) ? 1 : 0, e.port);
          check({e.tag, "_is_err"}, (req0_err || req1_err) ? 1 : 0, e.is_err);
          check({e.tag, "_result"}, result, e.val);
        end
      end
    end
  end

  task automatic push_job(input int p, input longint m, input longint e, input longint n, input string tag);
    exp_t x;
    x.port = p; x.is_err = 1'b0; x.val = modexp(m, e, n); x.tag = tag;
    sb.push_back(x);
    last_res = x.val;
  endtask

  task automatic push_err(input int p, input string tag);
    exp_t x;
    x.port = p; x.is_err = 1'b1; x.val = last_res; x.tag = tag;
    sb.push_back(x);
  endtask

  // Called just after a posedge; returns just after the posedge that accepted.
  task automatic send(input int p, input longint m, input longint e, input longint n);
    bit ok = 1'b0;
    longint one = 65536 % n;
    if (p == 0) begin
      req0_msg = B'(m); req0_exp = B'(e); req0_N = B'(n); req0_N_prime = B'(calc_np(n));
      req0_one = B'(one); req0_r2 = B'((one * one) % n); req0_valid = 1'b1;
    end else begin
      req1_msg = B'(m); req1_exp = B'(e); req1_N = B'(n); req1_N_prime = B'(calc_np(n));
      req1_one = B'(one); req1_r2 = B'((one * one) % n); req1_valid = 1'b1;
    end
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = (p == 0) ? req0_ready : req1_ready;
    end
    @(posedge clk);
    #1;
    if (p == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
    if (!ok) check($sformatf("accept_timeout_p%0d", p), 0, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 1000 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    check({tag, "_ctrl"}, {req0_ready, req1_ready, req0_done, req1_done, req0_err, req1_err, eng_start}, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_eng_ops"}, eng_base_mont | eng_exponent | eng_N | eng_N_prime | eng_one_mont, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "simulation time limit");
  end

  initial begin
    longint n, m, e;
    int     p;
    bit     seen;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_msg = '0; req0_exp = '0; req0_N = '0; req0_N_prime = '0; req0_r2 = '0; req0_one = '0;
    req1_msg = '0; req1_exp = '0; req1_N = '0; req1_N_prime = '0; req1_r2 = '0; req1_one = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_all_zero("reset");

    // Port 0 alone.
    eng_lat = 4;
    push_job(0, 5, 3, 13, "p0_only");
    send(0, 5, 3, 13);
    wait_drain();
    check("p0_start_delay", start_cyc - acc_cyc, 2);

    // Port 1 alone, latency measured against the engine's WAIT cycles.
    eng_lat = 6;
    push_job(1, 2, 10, 251, "p1_only");
    send(1, 2, 10, 251);
    wait_drain();
    check("p1_latency", evt_cyc - acc_cyc + 1, 5 + (fin_cyc - start_cyc));

    // Both ports held valid after reset: grants alternate 0,1,0,1.
    pulse_reset();
    eng_lat = 1;
    push_job(0, 5, 3, 13, "alt0");
    push_job(1, 2, 10, 251, "alt1");
    push_job(0, 7, 0, 13, "alt2_exp0");
    push_job(1, 7, 1, 13, "alt3_exp1");
    fork
      begin send(0, 5, 3, 13); send(0, 7, 0, 13); end
      begin send(1, 2, 10, 251); send(1, 7, 1, 13); end
    join
    wait_drain();

    // Finish in the same cycle the watchdog saturates: finish wins.
    eng_lat = 16;
    push_job(0, 3, 5, 13, "finish_tie");
    send(0, 3, 5, 13);
    wait_drain();

    // Engine never finishes: err strobe 15 cycles after WAIT is entered.
    eng_hang = 1'b1;
    push_err(1, "timeout");
    send(1, 4, 4, 13);
    wait_drain();
    check("timeout_delay", evt_cyc - (start_cyc + 1), 15);
    eng_hang = 1'b0;
    eng_lat  = 3;
    push_job(1, 6, 5, 13, "after_timeout");
    send(1, 6, 5, 13);
    wait_drain();

    // Reset while the job is in WAIT.
    eng_hang = 1'b1;
    send(0, 5, 3, 13);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = eng_start;
    end
    check("rst_test_started", seen, 1);
    repeat (3) @(posedge clk);
    #1 pulse_reset();
    check_all_zero("mid_wait_reset");
    repeat (20) @(posedge clk);
    #1 eng_hang = 1'b0;
    eng_lat = 5;
    push_job(1, 2, 10, 251, "after_reset");
    send(1, 2, 10, 251);
    wait_drain();

    // A few random jobs with full-width odd moduli.
    for (int k = 0; k < 4; k++) begin
      n = longint'($urandom_range(65535, 3)) | 1;
      m = longint'($urandom_range(32'(n - 1), 0));
      e = longint'($urandom_range(65535, 0));
      p = k % 2;
      eng_lat = int'($urandom_range(15, 1));
      push_job(p, m, e, n, $sformatf("rand%0d", k));
      send(p, m, e, n);
      wait_drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
